// File: rtl/trigger_sequencer_pkg.sv
// trigger_sequencer_pkg: mode/state encodings and the shared capture RAM address width
package trigger_sequencer_pkg;
  localparam int TRIG_ADDR_W = 10;
  typedef enum logic [1:0] {
    TRIG_MODE_AUTO   = 2'd0,
    TRIG_MODE_NORMAL = 2'd1,
    TRIG_MODE_SINGLE = 2'd2
  } trig_mode_t;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4,
    ST_HOLD = 3'd5
  } trig_state_t;
  function automatic logic [31:0] cnt_init(input logic [31:0] n);
    return (n == 32'd0) ? 32'd0 : n - 32'd1;
  endfunction
endpackage

// File: rtl/trigger_sequencer_counter.sv
// trigger_seq_counter: loadable down-counter with terminal-count flag
module trigger_seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  end
  assign tc = cnt == '0;
endmodule

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: scope acquisition sequencer (pre-fill, armed wait, post count, handshake, holdoff).
// Define TRIGGER_SEQ_FORCE_EN to add the Force input that triggers from WAIT without an edge.
module trigger_sequencer
  import trigger_sequencer_pkg::*;
#(
  parameter int ADDR_W = TRIG_ADDR_W,
  parameter int HOLD_W = 16,
  parameter int AUTO_W = 24
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              Trig,
  input  logic              Arm,
  input  logic              Stop,
  input  logic [1:0]        Mode,
  input  logic [ADDR_W-1:0] PreCount,
  input  logic [ADDR_W-1:0] PostCount,
  input  logic [HOLD_W-1:0] Holdoff,
  input  logic [AUTO_W-1:0] AutoTimeout,
  input  logic              Ack,
`ifdef TRIGGER_SEQ_FORCE_EN
  input  logic              Force,
`endif
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [ADDR_W-1:0] TrigAddr,
  output logic              Done,
  output logic              Triggered,
  output logic [2:0]        State
);
  localparam int CNT_W = (AUTO_W > HOLD_W) ? ((AUTO_W > ADDR_W) ? AUTO_W : ADDR_W)
                                           : ((HOLD_W > ADDR_W) ? HOLD_W : ADDR_W);
  trig_state_t       st, nxt;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] pre_q, post_q;
  logic [HOLD_W-1:0] hold_q;
  logic [AUTO_W-1:0] auto_q;
  logic              trig_q, trig_edge, tc, start, fire, force_hit;
  logic [CNT_W-1:0]  ld_val;
  assign trig_edge = Trig & ~trig_q;
`ifdef TRIGGER_SEQ_FORCE_EN
  assign force_hit = Force;
`else
  assign force_hit = 1'b0;
`endif
  assign fire = st == ST_WAIT && (trig_edge || force_hit || (mode_q == TRIG_MODE_AUTO && tc));
  // a new capture latches its configuration from the live inputs on the same edge it starts
  assign start = !Stop && ((st == ST_IDLE && Arm) ||
                           (st == ST_HOLD && tc && mode_q != TRIG_MODE_SINGLE));
  always_comb begin
    nxt = st;
    case (st)
      ST_IDLE: nxt = Arm ? (PreCount == '0 ? ST_WAIT : ST_PRE) : ST_IDLE;
      ST_PRE:  nxt = tc ? ST_WAIT : ST_PRE;
      ST_WAIT: nxt = fire ? (post_q == '0 ? ST_DONE : ST_POST) : ST_WAIT;
      ST_POST: nxt = tc ? ST_DONE : ST_POST;
      ST_DONE: nxt = Ack ? ST_HOLD : ST_DONE;
      ST_HOLD: nxt = !tc ? ST_HOLD : mode_q == TRIG_MODE_SINGLE ? ST_IDLE :
                     PreCount == '0 ? ST_WAIT : ST_PRE;
      default: nxt = ST_IDLE;
    endcase
    if (Stop) nxt = ST_IDLE;
  end
  // counter holds (cycles remaining - 1) so terminal count marks the last cycle of a phase
  assign ld_val = CNT_W'(nxt == ST_PRE  ? cnt_init(32'(start ? PreCount : pre_q)) :
                         nxt == ST_WAIT ? cnt_init(32'(start ? AutoTimeout : auto_q)) :
                         nxt == ST_POST ? cnt_init(32'(post_q)) :
                                          cnt_init(32'(hold_q)));
  trigger_seq_counter #(.W(CNT_W)) u_cnt (
    .clk      (Clk),
    .rst_n    (nReset),
    .load     (nxt != st),
    .load_val (ld_val),
    .tc       (tc)
  );
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      st        <= ST_IDLE;
      WrEn      <= 1'b0;
      WrAddr    <= '0;
      TrigAddr  <= '0;
      Done      <= 1'b0;
      Triggered <= 1'b0;
      trig_q    <= 1'b1;
      mode_q    <= '0;
      pre_q     <= '0;
      post_q    <= '0;
      hold_q    <= '0;
      auto_q    <= '0;
    end else begin
      st     <= nxt;
      trig_q <= Trig;
      WrEn   <= nxt inside {ST_PRE, ST_WAIT, ST_POST};
      Done   <= nxt == ST_DONE;
      if (!Stop) WrAddr <= WrAddr + ADDR_W'(WrEn);
      if (fire && !Stop) begin
        TrigAddr  <= WrAddr;
        Triggered <= trig_edge;
      end
      if (start) begin
        mode_q <= Mode;
        pre_q  <= PreCount;
        post_q <= PostCount;
        hold_q <= Holdoff;
        auto_q <= AutoTimeout;
      end
    end
  end
  assign State = st;
endmodule

// File: tb/tb_trigger_sequencer.sv
// tb_trigger_sequencer: scoreboard bench; writes and captures queued by stimulus, checked by a monitor
module tb_trigger_sequencer;
  import trigger_sequencer_pkg::*;
  localparam int AW = 4;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          trg;
  } cap_t;
  logic          Clk = 1'b0, nReset = 1'b0, Trig = 1'b0, Arm = 1'b0, Stop = 1'b0, Ack = 1'b0;
  logic [1:0]    Mode = 2'd0;
  logic [AW-1:0] PreCount = '0, PostCount = '0;
  logic [15:0]   Holdoff = '0;
  logic [23:0]   AutoTimeout = '0;
`ifdef TRIGGER_SEQ_FORCE_EN
  logic          Force = 1'b0;
`endif
  logic          WrEn, Done, Triggered;
  logic [AW-1:0] WrAddr, TrigAddr;
  logic [2:0]    State;
  int            checks = 0, errors = 0;
  logic [AW-1:0] wq[$];
  cap_t          cq[$];
  logic [AW-1:0] exp_addr = '0;
  logic          done_d = 1'b0;

  trigger_sequencer #(.ADDR_W(AW)) dut (
    .Clk(Clk), .nReset(nReset), .Trig(Trig), .Arm(Arm), .Stop(Stop), .Mode(Mode),
    .PreCount(PreCount), .PostCount(PostCount), .Holdoff(Holdoff), .AutoTimeout(AutoTimeout),
    .Ack(Ack),
`ifdef TRIGGER_SEQ_FORCE_EN
    .Force(Force),
`endif
    .WrEn(WrEn), .WrAddr(WrAddr), .TrigAddr(TrigAddr), .Done(Done), .Triggered(Triggered),
    .State(State)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_writes(input int n);
    for (int i = 0; i < n; i++) begin
      wq.push_back(exp_addr);
      exp_addr++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, State, ST_IDLE);
    check({tag, "_wren"}, WrEn, 0);
    check({tag, "_wraddr"}, WrAddr, 0);
    check({tag, "_trigaddr"}, TrigAddr, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_triggered"}, Triggered, 0);
  endtask

  always @(negedge Clk) begin
    cap_t c;
    if (WrEn === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got addr %0d want no write", WrAddr);
      end else check("wr_addr", int'(WrAddr), int'(wq.pop_front()));
    end
    if (Done === 1'b1 && !done_d) begin
      if (cq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got trig_addr %0d want no capture", TrigAddr);
      end else begin
        c = cq.pop_front();
        check("cap_trig_addr", TrigAddr, c.addr);
        check("cap_triggered", Triggered, c.trg);
      end
    end
    done_d = (Done === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    check_reset_vals("rst");
    nReset = 1'b1;
    tick();
    // NORMAL: 3 pre writes, edge at address 10, 4 post writes
    Mode = 2'd1; PreCount = 4'd3; PostCount = 4'd4; Holdoff = 16'd0; AutoTimeout = 24'd0; Arm = 1'b1;
    push_writes(11); cq.push_back('{addr: 4'd10, trg: 1'b1}); push_writes(4);
    tick(); Arm = 1'b0;
    check("t1_pre_state", State, ST_PRE);
    check("t1_pre_wren", WrEn, 1);
    repeat (10) tick();
    Trig = 1'b1; tick(); Trig = 1'b0;
    check("t1_post_state", State, ST_POST);
    check("t1_trig_addr", TrigAddr, 10);
    repeat (4) tick();
    check("t1_done", Done, 1);
    check("t1_done_wren", WrEn, 0);
    check("t1_done_addr", WrAddr, 15);
    Stop = 1'b1; tick(); Stop = 1'b0;
    check("t1_stop_state", State, ST_IDLE);
    check("t1_stop_done", Done, 0);
    // AUTO: forced trigger after 5 WAIT cycles, then holdoff 2 and re-entry into PRE
    Mode = 2'd0; PreCount = 4'd2; PostCount = 4'd1; Holdoff = 16'd2; AutoTimeout = 24'd5; Arm = 1'b1;
    push_writes(7); cq.push_back('{addr: 4'd5, trg: 1'b0}); push_writes(1);
    tick(); Arm = 1'b0;
    repeat (6) tick();
    check("t2_wait_state", State, ST_WAIT);
    tick();
    check("t2_post_state", State, ST_POST);
    check("t2_trig_addr", TrigAddr, 5);
    tick();
    check("t2_done", Done, 1);
    check("t2_done_state", State, ST_DONE);
    Ack = 1'b1; tick(); Ack = 1'b0;
    check("t2_hold_state", State, ST_HOLD);
    check("t2_ack_done", Done, 0);
    push_writes(1);
    tick();
    check("t2_hold2_state", State, ST_HOLD);
    tick();
    check("t2_rearm_state", State, ST_PRE);
    check("t2_rearm_wren", WrEn, 1);
    Stop = 1'b1; tick(); Stop = 1'b0;
    exp_addr--;
    check("t2_stop_state", State, ST_IDLE);
    check("t2_stop_addr", WrAddr, 7);
    // SINGLE: one capture, Ack -> HOLD -> IDLE, later edges ignored
    Mode = 2'd2; PreCount = 4'd1; PostCount = 4'd2; Holdoff = 16'd0; AutoTimeout = 24'd0; Arm = 1'b1;
    push_writes(2); cq.push_back('{addr: 4'd8, trg: 1'b1}); push_writes(2);
    tick(); Arm = 1'b0;
    tick();
    check("t3_wait_state", State, ST_WAIT);
    Trig = 1'b1; tick(); Trig = 1'b0;
    check("t3_post_state", State, ST_POST);
    check("t3_trig_addr", TrigAddr, 8);
    repeat (2) tick();
    check("t3_done", Done, 1);
    Ack = 1'b1; tick(); Ack = 1'b0;
    check("t3_hold_state", State, ST_HOLD);
    tick();
    check("t3_idle_state", State, ST_IDLE);
    repeat (3) begin
      Trig = 1'b1; tick(); Trig = 1'b0; tick();
    end
    check("t3_idle_after_edges", State, ST_IDLE);
    check("t3_idle_wren", WrEn, 0);
    // AUTO: WAIT at address 15 wraps to 0; edge coincides with timeout
    Mode = 2'd0; PreCount = 4'd2; PostCount = 4'd1; AutoTimeout = 24'd3; Arm = 1'b1;
    push_writes(5); cq.push_back('{addr: 4'd15, trg: 1'b1}); push_writes(1);
    tick(); Arm = 1'b0;
    repeat (4) tick();
    check("t4_wait_state", State, ST_WAIT);
    check("t4_wait_addr", WrAddr, 15);
    Trig = 1'b1; tick(); Trig = 1'b0;
    check("t4_post_state", State, ST_POST);
    check("t4_wrap_addr", WrAddr, 0);
    check("t4_trig_addr", TrigAddr, 15);
    tick();
    check("t4_done", Done, 1);
    check("t4_triggered", Triggered, 1);
    Stop = 1'b1; tick(); Stop = 1'b0;
    // PreCount = 0 goes straight to WAIT; Stop during POST
    Mode = 2'd1; PreCount = 4'd0; PostCount = 4'd5; Arm = 1'b1;
    push_writes(3);
    tick(); Arm = 1'b0;
    check("t5_wait_state", State, ST_WAIT);
    Trig = 1'b1; tick(); Trig = 1'b0;
    check("t5_post_state", State, ST_POST);
    check("t5_trig_addr", TrigAddr, 1);
    tick();
    Stop = 1'b1; tick(); Stop = 1'b0;
    exp_addr--;
    check("t5_stop_state", State, ST_IDLE);
    check("t5_stop_wren", WrEn, 0);
    check("t5_stop_done", Done, 0);
    check("t5_stop_addr", WrAddr, 3);
    // reset during WAIT
    Mode = 2'd1; PreCount = 4'd1; PostCount = 4'd1; Arm = 1'b1;
    push_writes(2);
    tick(); Arm = 1'b0;
    tick();
    check("t6_wait_state", State, ST_WAIT);
    nReset = 1'b0; tick();
    check_reset_vals("t6_rst");
    nReset = 1'b1; exp_addr = '0;
    tick();
`ifdef TRIGGER_SEQ_FORCE_EN
    Mode = 2'd1; PreCount = 4'd1; PostCount = 4'd1; Arm = 1'b1;
    push_writes(2); cq.push_back('{addr: 4'd1, trg: 1'b0}); push_writes(1);
    tick(); Arm = 1'b0;
    tick();
    Force = 1'b1; tick(); Force = 1'b0;
    check("t7_post_state", State, ST_POST);
    check("t7_triggered", Triggered, 0);
    tick();
    check("t7_done_state", State, ST_DONE);
    Force = 1'b1; tick(); Force = 1'b0;
    check("t7_force_done_state", State, ST_DONE);
    check("t7_force_done", Done, 1);
    Stop = 1'b1; tick(); Stop = 1'b0;
`endif
    repeat (2) tick();
    check("wq_empty", wq.size(), 0);
    check("cq_empty", cq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
